// File: rtl/mem_arbiter_2p.sv
// mem_arbiter_2p: two-requester round-robin arbiter/sequencer for an 8x8 negedge-clocked memory
// Ports: clk, reset (async, active-high); req_valid/req_ready/req_op[1:0], req_addr0/1, req_wdata0/1 (command side);
//        rsp_valid[1:0], rsp_rdata (one-cycle completion); mem_op/mem_addr/mem_wdata out, mem_rdata in (memory side).
// Optional: MEM_ARB_STATS_EN adds stat_clr, stat_cnt0, stat_cnt1 (saturating per-requester accept counters).
module mem_arbiter_2p #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
`ifdef MEM_ARB_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
  , input  logic             stat_clr,
  output logic [CNT_W-1:0]   stat_cnt0,
  output logic [CNT_W-1:0]   stat_cnt1
`endif
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_nx;
  logic grant, last_grant, cur_grant, fire;
  // ready is gated by reset so it drops the instant reset is asserted, not at the next edge
  always_comb begin
    grant = &req_valid ? ~last_grant : req_valid[1];
    req_ready = (state == IDLE && !reset && |req_valid) ? {grant, ~grant} : 2'b00;
    fire = |req_ready;
    state_nx = (state == IDLE && fire) ? ACCESS : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // mem_op doubles as the captured op of the access in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
      mem_op <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      cur_grant <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      rsp_valid <= 2'b00;
      if (fire) begin
        mem_op <= req_op[grant];
        mem_addr <= grant ? req_addr1 : req_addr0;
        mem_wdata <= grant ? req_wdata1 : req_wdata0;
        cur_grant <= grant;
        last_grant <= grant;
      end
      if (state == ACCESS) begin
        mem_op <= 1'b0;
        rsp_valid <= {cur_grant, ~cur_grant};
        rsp_rdata <= mem_op ? '0 : mem_rdata;
      end
    end
  end
`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset || stat_clr) begin
      stat_cnt0 <= '0;
      stat_cnt1 <= '0;
    end else begin
      if (req_ready[0] && !(&stat_cnt0)) stat_cnt0 <= stat_cnt0 + 1'b1;
      if (req_ready[1] && !(&stat_cnt1)) stat_cnt1 <= stat_cnt1 + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_arbiter_2p.sv
// tb_mem_arbiter_2p: directed table-driven bench for mem_arbiter_2p with a negedge memory model
module tb_mem_arbiter_2p;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] req_valid = 2'b00, req_op = 2'b00;
  logic [2:0] req_addr0 = '0, req_addr1 = '0;
  logic [7:0] req_wdata0 = '0, req_wdata1 = '0;
  logic [1:0] req_ready, rsp_valid;
  logic [7:0] rsp_rdata, mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic [2:0] mem_addr;
  logic mem_op;
  logic [7:0] mem [8];
  int total = 0, bad = 0;
`ifdef MEM_ARB_STATS_EN
  logic stat_clr = 1'b0;
  logic [1:0] stat_cnt0, stat_cnt1;
  mem_arbiter_2p #(.CNT_W(2)) dut (
`else
  mem_arbiter_2p dut (
`endif
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr0(req_addr0), .req_addr1(req_addr1), .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_op(mem_op), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1)
`endif
  );
  always #5 clk = ~clk;
  initial for (int i = 0; i < 8; i++) mem[i] = 8'h00;
  always @(negedge clk) begin
    if (mem_op) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end
  typedef struct {
    logic [1:0] valid, op;
    logic [2:0] a0, a1;
    logic [7:0] d0, d1;
    logic [1:0] ready, rsp;
    logic [7:0] rdata;
    logic       mop;
  } vec_t;
  vec_t vt [23];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic xfer(input logic g, input logic op, input logic [2:0] a, input logic [7:0] d,
                      input logic [7:0] er, input logic chk_r);
    req_valid = g ? 2'b10 : 2'b01;
    req_op = {op, op};
    req_addr0 = a;
    req_addr1 = a;
    req_wdata0 = d;
    req_wdata1 = d;
    #1 chk("xfer_ready", req_ready, req_valid);
    tick();
    req_valid = 2'b00;
    tick();
    #1 chk("xfer_rsp", rsp_valid, g ? 2'b10 : 2'b01);
    if (chk_r) chk("xfer_rdata", rsp_rdata, er);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    //           valid  op     a0    a1    d0     d1     ready  rsp    rdata  mop
    vt[0]  = '{2'b01, 2'b01, 3'd3, 3'd0, 8'hA5, 8'h00, 2'b01, 2'b00, 8'h00, 1'b0};
    vt[1]  = '{2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b1};
    vt[2]  = '{2'b01, 2'b00, 3'd3, 3'd0, 8'h00, 8'h00, 2'b01, 2'b01, 8'h00, 1'b0};
    vt[3]  = '{2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0};
    vt[4]  = '{2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 2'b01, 8'hA5, 1'b0};
    vt[5]  = '{2'b11, 2'b00, 3'd3, 3'd3, 8'h00, 8'h00, 2'b10, 2'b00, 8'h00, 1'b0};
    vt[6]  = '{2'b11, 2'b00, 3'd3, 3'd3, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0};
    vt[7]  = '{2'b11, 2'b00, 3'd3, 3'd3, 8'h00, 8'h00, 2'b01, 2'b10, 8'hA5, 1'b0};
    vt[8]  = '{2'b11, 2'b00, 3'd3, 3'd3, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0};
    vt[9]  = '{2'b11, 2'b00, 3'd3, 3'd3, 8'h00, 8'h00, 2'b10, 2'b01, 8'hA5, 1'b0};
    vt[10] = '{2'b11, 2'b00, 3'd3, 3'd3, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0};
    vt[11] = '{2'b11, 2'b00, 3'd3, 3'd3, 8'h00, 8'h00, 2'b01, 2'b10, 8'hA5, 1'b0};
    vt[12] = '{2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0};
    vt[13] = '{2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 2'b01, 8'hA5, 1'b0};
    vt[14] = '{2'b10, 2'b10, 3'd0, 3'd7, 8'h00, 8'hFF, 2'b10, 2'b00, 8'h00, 1'b0};
    vt[15] = '{2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b1};
    vt[16] = '{2'b10, 2'b10, 3'd0, 3'd0, 8'h00, 8'h01, 2'b10, 2'b10, 8'h00, 1'b0};
    vt[17] = '{2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b1};
    vt[18] = '{2'b10, 2'b00, 3'd0, 3'd7, 8'h00, 8'h00, 2'b10, 2'b10, 8'h00, 1'b0};
    vt[19] = '{2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0};
    vt[20] = '{2'b10, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b10, 2'b10, 8'hFF, 1'b0};
    vt[21] = '{2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0};
    vt[22] = '{2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 2'b10, 8'h01, 1'b0};
    #3;
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_rdata", rsp_rdata, 8'h00);
    chk("rst_mem_op", mem_op, 1'b0);
    chk("rst_mem_addr", mem_addr, 3'd0);
    chk("rst_mem_wdata", mem_wdata, 8'h00);
    #19;
    reset = 1'b0;
    req_valid = 2'b11;
    #1 chk("first_contended_grant", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("first_access_ready", req_ready, 2'b00);
    tick();
    chk("first_rsp", rsp_valid, 2'b01);
    for (int i = 0; i < 23; i++) begin
      tick();
      req_valid = vt[i].valid;
      req_op = vt[i].op;
      req_addr0 = vt[i].a0;
      req_addr1 = vt[i].a1;
      req_wdata0 = vt[i].d0;
      req_wdata1 = vt[i].d1;
      #1;
      chk($sformatf("v%0d_ready", i), req_ready, vt[i].ready);
      chk($sformatf("v%0d_rsp_valid", i), rsp_valid, vt[i].rsp);
      chk($sformatf("v%0d_mem_op", i), mem_op, vt[i].mop);
      if (vt[i].rsp != 2'b00) chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, vt[i].rdata);
    end
    tick();
    req_valid = 2'b01;
    req_op = 2'b00;
    req_addr0 = 3'd5;
    req_wdata0 = 8'h3C;
    tick();
    chk("rd_access_addr", mem_addr, 3'd5);
    chk("rd_access_wdata", mem_wdata, 8'h3C);
    #2 reset = 1'b1;
    #1;
    chk("rd_abort_mem_addr", mem_addr, 3'd0);
    chk("rd_abort_mem_wdata", mem_wdata, 8'h00);
    chk("rd_abort_rsp_rdata", rsp_rdata, 8'h00);
    chk("rd_abort_ready", req_ready, 2'b00);
    chk("rd_abort_mem_op", mem_op, 1'b0);
    tick();
    chk("rd_abort_no_rsp", rsp_valid, 2'b00);
    #2 reset = 1'b0;
    req_valid = 2'b00;
    tick();
    chk("rd_abort_idle_no_rsp", rsp_valid, 2'b00);
    xfer(1'b0, 1'b1, 3'd4, 8'h5A, 8'h00, 1'b1);
    xfer(1'b0, 1'b0, 3'd4, 8'h00, 8'h5A, 1'b1);
    req_valid = 2'b10;
    req_op = 2'b10;
    req_addr1 = 3'd2;
    req_wdata1 = 8'h77;
    tick();
    req_valid = 2'b00;
    chk("wr_access_mem_op", mem_op, 1'b1);
    #2 reset = 1'b1;
    #1 chk("wr_abort_mem_op", mem_op, 1'b0);
    tick();
    chk("wr_abort_no_rsp", rsp_valid, 2'b00);
    #2 reset = 1'b0;
    req_valid = 2'b11;
    req_op = 2'b00;
    #1 chk("post_reset_grant0", req_ready, 2'b01);
    req_valid = 2'b00;
    xfer(1'b1, 1'b1, 3'd6, 8'hC3, 8'h00, 1'b1);
    xfer(1'b1, 1'b0, 3'd6, 8'h00, 8'hC3, 1'b1);
`ifdef MEM_ARB_STATS_EN
    chk("stat_init0", stat_cnt0, 2'd0);
    chk("stat_init1", stat_cnt1, 2'd2);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("stat_clr0a", stat_cnt0, 2'd0);
    chk("stat_clr1a", stat_cnt1, 2'd0);
    for (int i = 0; i < 3; i++) xfer(1'b0, 1'b0, 3'd1, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 2; i++) xfer(1'b1, 1'b0, 3'd1, 8'h00, 8'h00, 1'b0);
    chk("stat_cnt0", stat_cnt0, 2'd3);
    chk("stat_cnt1", stat_cnt1, 2'd2);
    xfer(1'b0, 1'b0, 3'd1, 8'h00, 8'h00, 1'b0);
    xfer(1'b1, 1'b0, 3'd1, 8'h00, 8'h00, 1'b0);
    chk("stat_sat0", stat_cnt0, 2'd3);
    chk("stat_cnt1_3", stat_cnt1, 2'd3);
    req_valid = 2'b01;
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    req_valid = 2'b00;
    chk("stat_clr_wins0", stat_cnt0, 2'd0);
    chk("stat_clr_wins1", stat_cnt1, 2'd0);
    tick();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
